// File: rtl/regs_operand_fetch.sv
// rtl/regs_operand_fetch.sv - operand fetch with busy scoreboard; REGS_OF_BYPASS_EN adds writeback bypass
module regs_operand_fetch #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int IW   = $clog2(NREGS)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            id_valid_i,
   output logic            id_ready_o,
   input  logic [IW-1:0]   id_rs1_i,
   input  logic [IW-1:0]   id_rs2_i,
   input  logic            id_rs1_used_i,
   input  logic            id_rs2_used_i,
   input  logic [IW-1:0]   id_rd_i,
   input  logic            id_rd_wr_i,
   output logic            rs_rd_en_o,
   output logic [IW-1:0]   rs1_o,
   output logic [IW-1:0]   rs2_o,
   input  logic [XLEN-1:0] rs1_rd_data_i,
   input  logic [XLEN-1:0] rs2_rd_data_i,
   input  logic            wb_valid_i,
   input  logic [IW-1:0]   wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            rd_wr_en_o,
   output logic [IW-1:0]   rd_o,
   output logic [XLEN-1:0] rd_wr_data_o,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic [XLEN-1:0] ex_rs1_data_o,
   output logic [XLEN-1:0] ex_rs2_data_o,
   output logic [IW-1:0]   ex_rd_o,
   output logic            ex_rd_wr_o,
   output logic [15:0]     stall_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_VALID} state_e;

   state_e            state_q, state_d;
   logic [NREGS-1:0]  busy_q, busy_d;
   logic              src1_live, src2_live, dst_live;
   logic              hazard, slot_free, accept;
   logic              src1_live_q, src2_live_q;
   logic [XLEN-1:0]   ex_rs1_q, ex_rs2_q;
   logic [IW-1:0]     ex_rd_q;
   logic              ex_rd_wr_q;
   logic [15:0]       stall_q;
`ifdef REGS_OF_BYPASS_EN
   logic              fwd1, fwd2;
   logic              byp1_q, byp2_q;
   logic [XLEN-1:0]   byp_data_q;
`endif

   // Source/destination liveness and RAW/WAW hazard detection against the scoreboard
   always_comb begin
      src1_live = id_rs1_used_i && (id_rs1_i != '0);
      src2_live = id_rs2_used_i && (id_rs2_i != '0);
      dst_live  = id_rd_wr_i && (id_rd_i != '0);
`ifdef REGS_OF_BYPASS_EN
      // A source produced by this cycle's writeback is taken from wb_data, so it need not wait
      fwd1   = src1_live && wb_valid_i && (wb_rd_i == id_rs1_i);
      fwd2   = src2_live && wb_valid_i && (wb_rd_i == id_rs2_i);
      hazard = (src1_live && busy_q[id_rs1_i] && !fwd1) ||
               (src2_live && busy_q[id_rs2_i] && !fwd2) ||
               (dst_live  && busy_q[id_rd_i]);
`else
      hazard = (src1_live && busy_q[id_rs1_i]) ||
               (src2_live && busy_q[id_rs2_i]) ||
               (dst_live  && busy_q[id_rd_i]);
`endif
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state; an accept in VALID overlaps the handoff and goes straight to READ
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_READ;
         S_READ:  state_d = S_VALID;
         S_VALID: if (ex_ready_i) state_d = accept ? S_READ : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: slot availability, accept and the execute-side valid
   always_comb begin
      slot_free  = (state_q == S_IDLE) || ((state_q == S_VALID) && ex_ready_i);
      id_ready_o = rst_ni && slot_free && !hazard;
      accept     = id_valid_i && id_ready_o;
      ex_valid_o = (state_q == S_VALID);
   end

   // Scoreboard next state: clear on writeback, then set on accept so set wins on a collision
   always_comb begin
      busy_d = busy_q;
      if (wb_valid_i && (wb_rd_i != '0)) busy_d[wb_rd_i] = 1'b0;
      if (accept && dst_live)            busy_d[id_rd_i] = 1'b1;
   end

   // Scoreboard and hazard-stall counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q  <= '0;
         stall_q <= '0;
      end else begin
         busy_q <= busy_d;
         if (id_valid_i && hazard && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      end
   end

   // Accept-time bookkeeping and operand capture in READ, when regs data is valid
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src1_live_q <= 1'b0;
         src2_live_q <= 1'b0;
         ex_rs1_q    <= '0;
         ex_rs2_q    <= '0;
         ex_rd_q     <= '0;
         ex_rd_wr_q  <= 1'b0;
`ifdef REGS_OF_BYPASS_EN
         byp1_q      <= 1'b0;
         byp2_q      <= 1'b0;
         byp_data_q  <= '0;
`endif
      end else begin
         if (accept) begin
            src1_live_q <= src1_live;
            src2_live_q <= src2_live;
            ex_rd_q     <= id_rd_i;
            ex_rd_wr_q  <= id_rd_wr_i;
`ifdef REGS_OF_BYPASS_EN
            byp1_q      <= fwd1;
            byp2_q      <= fwd2;
            byp_data_q  <= wb_data_i;
`endif
         end
         if (state_q == S_READ) begin
            ex_rs1_q <= src1_live_q ? rs1_rd_data_i : '0;
            ex_rs2_q <= src2_live_q ? rs2_rd_data_i : '0;
`ifdef REGS_OF_BYPASS_EN
            if (byp1_q) ex_rs1_q <= byp_data_q;
            if (byp2_q) ex_rs2_q <= byp_data_q;
`endif
         end
      end
   end

   assign rs_rd_en_o    = accept;
   assign rs1_o         = id_rs1_i;
   assign rs2_o         = id_rs2_i;
   assign rd_wr_en_o    = wb_valid_i && rst_ni;
   assign rd_o          = wb_rd_i;
   assign rd_wr_data_o  = wb_data_i;
   assign ex_rs1_data_o = ex_rs1_q;
   assign ex_rs2_data_o = ex_rs2_q;
   assign ex_rd_o       = ex_rd_q;
   assign ex_rd_wr_o    = ex_rd_wr_q;
   assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_regs_operand_fetch.sv
// tb/tb_regs_operand_fetch.sv - scoreboard bench for regs_operand_fetch with a regs model
module tb_regs_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_ready;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_rs1_used, id_rs2_used, id_rd_wr;
   logic        rs_rd_en;
   logic [4:0]  rs1, rs2;
   logic [31:0] rs1_rd_data, rs2_rd_data;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        rd_wr_en;
   logic [4:0]  rd;
   logic [31:0] rd_wr_data;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_rs1_data, ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_rd_wr;
   logic [15:0] stall_cnt;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic        rd_wr;
      int          acc_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [32];
   logic [31:0] mem [32];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          bp_rdcnt = 0;
   logic        ev_prev = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] snap_rs1, snap_rs2;
   logic [4:0]  snap_rd;
   logic [15:0] stall0;
`ifdef REGS_OF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regs_operand_fetch dut (
      .clk_i(clk), .rst_ni(rst_n),
      .id_valid_i(id_valid), .id_ready_o(id_ready),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
      .id_rd_i(id_rd), .id_rd_wr_i(id_rd_wr),
      .rs_rd_en_o(rs_rd_en), .rs1_o(rs1), .rs2_o(rs2),
      .rs1_rd_data_i(rs1_rd_data), .rs2_rd_data_i(rs2_rd_data),
      .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .rd_wr_en_o(rd_wr_en), .rd_o(rd), .rd_wr_data_o(rd_wr_data),
      .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
      .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
      .ex_rd_o(ex_rd), .ex_rd_wr_o(ex_rd_wr),
      .stall_cnt_o(stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // regs model: registered read (old value on a same-edge write), writable x0
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         rs1_rd_data <= '0;
         rs2_rd_data <= '0;
      end else begin
         if (rd_wr_en) mem[rd] <= rd_wr_data;
         if (rs_rd_en) begin
            rs1_rd_data <= mem[rs1];
            rs2_rd_data <= mem[rs2];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // monitor: pop/compare on handoff, push on accept, latency and hold-stability checks
   always @(negedge clk) begin
      if (rst_n) begin
         if (ex_valid && !ev_prev && sb.size() > 0)
            check_eq("latency", 64'(cyc - sb[0].acc_cyc), 64'd2);
         if (ex_valid && hold_prev) begin
            check_eq("hold_rs1", ex_rs1_data, snap_rs1);
            check_eq("hold_rs2", ex_rs2_data, snap_rs2);
            check_eq("hold_rd", ex_rd, snap_rd);
         end
         if (ex_valid && !ex_ready && rs_rd_en) bp_rdcnt++;
         if (ex_valid && ex_ready) begin
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check_eq("ex_rs1", ex_rs1_data, e.rs1);
               check_eq("ex_rs2", ex_rs2_data, e.rs2);
               check_eq("ex_rd", ex_rd, e.rd);
               check_eq("ex_rd_wr", ex_rd_wr, e.rd_wr);
            end
         end
         if (id_valid && id_ready) begin
            exp_t e;
            e.rs1     = (id_rs1_used && id_rs1 != 0) ? model[id_rs1] : 32'd0;
            e.rs2     = (id_rs2_used && id_rs2 != 0) ? model[id_rs2] : 32'd0;
            e.rd      = id_rd;
            e.rd_wr   = id_rd_wr;
            e.acc_cyc = cyc;
            sb.push_back(e);
         end
      end
      ev_prev   = ex_valid;
      hold_prev = ex_valid && !ex_ready;
      snap_rs1  = ex_rs1_data;
      snap_rs2  = ex_rs2_data;
      snap_rd   = ex_rd;
   end

   // all driver tasks start and end just after a rising edge
   task automatic wb_write(input logic [4:0] idx, input logic [31:0] data);
      wb_valid = 1'b1;
      wb_rd    = idx;
      wb_data  = data;
      if (idx != 0) model[idx] = data;
      @(posedge clk); #1;
      wb_valid = 1'b0;
   endtask

   task automatic issue(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] d, input logic w);
      bit ok;
      int k;
      ok = 0;
      k = 0;
      id_rs1 = r1; id_rs1_used = u1;
      id_rs2 = r2; id_rs2_used = u2;
      id_rd  = d;  id_rd_wr    = w;
      id_valid = 1'b1;
      while (!ok && k < 50) begin
         @(negedge clk);
         if (id_ready) ok = 1;
         k++;
      end
      check_eq("issue_accept", ok, 1);
      @(posedge clk); #1;
      id_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq("drain", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      rst_n = 1'b0;
      id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
      id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rd_wr = 1'b1;
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
      ex_ready = 1'b1;

      // reset held for 5 cycles with activity on the inputs
      repeat (5) begin
         @(negedge clk);
         check_eq("rst_id_ready", id_ready, 0);
         check_eq("rst_ex_valid", ex_valid, 0);
         check_eq("rst_rd_wr_en", rd_wr_en, 0);
         check_eq("rst_rs_rd_en", rs_rd_en, 0);
         check_eq("rst_stall_cnt", stall_cnt, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      id_valid = 1'b0;
      wb_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst_ex_rd", ex_rd, 0);
      check_eq("post_rst_stall", stall_cnt, 0);

      // basic read
      wb_write(5'd3, 32'hDEADBEEF);
      wb_write(5'd4, 32'h12345678);
      issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1);
      drain();

      // x0 and unused source
      wb_write(5'd7, 32'h77777777);
      wb_write(5'd0, 32'hFFFFFFFF);
      issue(5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
      drain();

      // RAW stall on x6
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
      drain();
      stall0 = stall_cnt;
      id_rs1 = 5'd6; id_rs1_used = 1'b1;
      id_rs2 = 5'd0; id_rs2_used = 1'b0;
      id_rd  = 5'd0; id_rd_wr    = 1'b0;
      id_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_eq("raw_stall", id_ready, 0);
         @(posedge clk); #1;
      end
      wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'hA5A5A5A5;
      model[6] = 32'hA5A5A5A5;
      @(negedge clk);
      check_eq("raw_wb_cycle_ready", id_ready, BYP);
      @(posedge clk); #1;
      wb_valid = 1'b0;
      if (!BYP) begin
         @(negedge clk);
         check_eq("raw_after_wb_ready", id_ready, 1);
         @(posedge clk); #1;
      end
      id_valid = 1'b0;
      check_eq("raw_stall_cnt", 16'(stall_cnt - stall0), BYP ? 16'd2 : 16'd3);
      drain();

      // backpressure with a second instruction pending
      ex_ready = 1'b0;
      bp_rdcnt = 0;
      issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
      id_rs1 = 5'd4; id_rs1_used = 1'b1;
      id_rs2 = 5'd3; id_rs2_used = 1'b1;
      id_rd  = 5'd0; id_rd_wr    = 1'b0;
      id_valid = 1'b1;
      begin
         int k;
         k = 0;
         @(negedge clk);
         while (!ex_valid && k < 10) begin
            @(negedge clk);
            k++;
         end
      end
      check_eq("bp_ex_valid", ex_valid, 1);
      check_eq("bp_blocked", id_ready, 0);
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_blocked", id_ready, 0);
      end
      @(posedge clk); #1;
      ex_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_accept", id_ready, 1);
      @(posedge clk); #1;
      id_valid = 1'b0;
      check_eq("bp_no_read", bp_rdcnt, 0);
      drain();

      // sweep: random contents, then adjacent pairs
      for (int i = 1; i < 32; i++) wb_write(5'(i), $urandom);
      for (int i = 0; i < 31; i++) issue(5'(i), 1'b1, 5'(i + 1), 1'b1, 5'd0, 1'b0);
      drain();

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regs_operand_fetch.md
# regs_operand_fetch

Decode-side client of the `regs` register file. It accepts decoded instructions and issues `rs1`/`rs2` reads into `regs`. It tracks outstanding destination writes in a per-register scoreboard, stalling on RAW/WAW hazards. It also forwards writeback traffic into the `regs` write port and presents captured operands to the execute stage through a valid/ready handshake.

## Interface
- `XLEN`, 32, data width.
- `NREGS`, 32, architectural registers; index width is `$clog2(NREGS)` = 5.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `id_valid` in 1: decoded instruction present.
- `id_ready` out 1: instruction accepted this cycle when `id_valid` is also high.
- `id_rs1`, `id_rs2` in 5: source indices.
- `id_rs1_used`, `id_rs2_used` in 1: the corresponding source is read.
- `id_rd` in 5: destination index.
- `id_rd_wr` in 1: the instruction writes `id_rd`.
- `rs_rd_en` out 1: read strobe to `regs`.
- `rs1`, `rs2` out 5: read indices to `regs`.
- `rs1_rd_data`, `rs2_rd_data` in XLEN: `regs` read data, valid the cycle after the strobe.
- `wb_valid` in 1, `wb_rd` in 5, `wb_data` in XLEN: writeback from the last pipeline stage.
- `rd_wr_en` out 1, `rd` out 5, `rd_wr_data` out XLEN: write port to `regs`.
- `ex_valid` out 1, `ex_ready` in 1: operand handshake to execute.
- `ex_rs1_data`, `ex_rs2_data` out XLEN; `ex_rd` out 5; `ex_rd_wr` out 1: captured operands and destination.
- `stall_cnt` out 16: saturating count of hazard-stall cycles.

## Operation
- FSM states and transitions:
  - IDLE: may accept. On accept, go to READ.
  - READ: `regs` data arriving. Capture into the `ex_*` registers, then go to VALID.
  - VALID: hold `ex_valid`=1. If `ex_ready` with no accept, go to IDLE. If `ex_ready` with an accept in the same cycle, go to READ.
- Hazard: a used source with nonzero index and `busy[idx]`=1, or `id_rd_wr`, `id_rd`≠0 and `busy[id_rd]`=1.
- `id_ready` = (IDLE, or VALID with `ex_ready`) and no hazard.
- Accept = `id_valid` and `id_ready`. This is combinational from current state and inputs.
- Read strobe: `rs_rd_en` = accept; `rs1`/`rs2` = `id_rs1`/`id_rs2` (combinational).
- Scoreboard set and clear:
  - On accept with `id_rd_wr` and `id_rd`≠0, set `busy[id_rd]`.
  - On `wb_valid` with `wb_rd`≠0, clear `busy[wb_rd]`.
  - Set and clear of the same index in the same cycle: set wins.
  - Writeback to a non-busy index is forwarded to `regs`; the scoreboard is unchanged.
- Operand capture:
  - An unused source captures 0.
  - Index 0 captures 0 regardless of `regs` output.
  - `ex_rd`/`ex_rd_wr` are latched at accept and presented with the operands.
- Write passthrough (combinational): `rd_wr_en` = `wb_valid` and `rst`=1; `rd` = `wb_rd`; `rd_wr_data` = `wb_data`.
- `stall_cnt` increments each cycle with `id_valid`=1 and `id_ready`=0 caused by a hazard. Cycles stalled only by a full VALID slot do not count. It saturates at 0xFFFF.

## Timing
- Reset values: state IDLE, `busy`=0, `ex_valid`=0, `ex_rs1_data`=`ex_rs2_data`=0, `ex_rd`=0, `ex_rd_wr`=0, `stall_cnt`=0.
- Reset forces combinational outputs `id_ready`, `rs_rd_en`, `rd_wr_en` to 0.
- Reset mid-operation: an in-flight instruction is dropped and all busy bits clear.
- Latency: accept at edge T, then `ex_valid`=1 after edge T+1.
- Back-to-back throughput is one instruction per 2 cycles; accept in VALID overlaps the handoff.
- `ex_*` outputs hold stable while `ex_valid`=1 and `ex_ready`=0.
- RAW without bypass: the busy bit clears at writeback edge W. The dependent instruction is accepted in cycle W+1, and its read returns the new value.

## Configuration
- `REGS_OF_BYPASS_EN` defined:
  - A hazard on a source whose index equals `wb_rd` with `wb_valid`=1 in the same cycle is not a hazard. WAW hazards still stall.
  - `wb_data` is latched at accept and substituted for that source's `regs` data in READ.
  - This saves one stall cycle per such dependency.
- `REGS_OF_BYPASS_EN` undefined: busy bits alone determine hazards, and no forwarding path exists.

## Test plan
- Reset: hold `rst`=0 for 5 cycles with `id_valid`=1 → `id_ready`=0, `ex_valid`=0, `rd_wr_en`=0, `stall_cnt`=0.
- Basic read:
  - Stimulus: writeback x3=0xDEADBEEF, then x4=0x12345678; then issue rs1=3, rs2=4, rd=5.
  - Required: `ex_valid` 2 cycles after accept with 0xDEADBEEF/0x12345678, `ex_rd`=5.
- x0 and unused sources:
  - Stimulus: writeback x0=0xFFFFFFFF, then issue rs1=0 (used), rs2=7 with `id_rs2_used`=0.
  - Required: both operands 0.
- RAW stall:
  - Stimulus: issue rd=6; issue rs1=6; hold writeback x6=0xA5A5A5A5 for 3 cycles, then write.
  - Required: `id_ready`=0 throughout, `stall_cnt`=3 without bypass, `ex_rs1_data`=0xA5A5A5A5.
  - Required with `REGS_OF_BYPASS_EN`: same-cycle accept, `stall_cnt`=2.
- Backpressure: hold `ex_ready`=0 for 4 cycles with a second instruction pending → `ex_*` stable, no second `rs_rd_en`, second accepted in the cycle `ex_ready` rises.
- Sweep: write x1..x31 with random data, then read pairs (0,1)…(30,31) → zero mismatches against a bench model.
